instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word addresses to a synchronous-read memory,
// registers the returned word for decode, and handles stall, redirect and halt.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int unsigned AW = 32;

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] infl_pc_q, infl_pc_d;
  logic          infl_v_q, infl_v_d;
  logic [AW-1:0] if_instr_d, if_pc_d;
  logic          if_valid_d, halted_d, fetch_fault_d;
  logic          target_legal, at_end;

  // While stalled, re-present the in-flight address so its word is still on the bus when stall drops.
  assign address      = (stall && infl_v_q) ? infl_pc_q : pc_q;
  assign target_legal = redirect_target < AW'(MEM_DEPTH);
  assign at_end       = pc_q >= AW'(MEM_DEPTH);

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      infl_pc_q   <= '0;
      infl_v_q    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_pc_q   <= infl_pc_d;
      infl_v_q    <= infl_v_d;
      if_instr    <= if_instr_d;
      if_pc       <= if_pc_d;
      if_valid    <= if_valid_d;
      halted      <= halted_d;
      fetch_fault <= fetch_fault_d;
    end
  end

  // Next-state and next-register logic; redirect outranks stall and halt.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    infl_pc_d     = infl_pc_q;
    infl_v_d      = infl_v_q;
    if_instr_d    = if_instr;
    if_pc_d       = if_pc;
    if_valid_d    = if_valid;
    fetch_fault_d = fetch_fault;

    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end else if (redirect_valid) begin
      infl_v_d   = 1'b0;
      if_valid_d = 1'b0;
      if (target_legal) begin
        pc_d    = redirect_target;
        state_d = S_RUN;
      end else begin
        fetch_fault_d = 1'b1;
        state_d       = S_HALTED;
      end
    end else if (!stall) begin
      if_instr_d = instruction;
      if_pc_d    = infl_pc_q;
      if_valid_d = infl_v_q;
      case (state_q)
        S_RUN: begin
          if (halt_req || at_end) begin
            infl_v_d = 1'b0;
            state_d  = S_DRAIN;
          end else begin
            infl_pc_d = pc_q;
            infl_v_d  = 1'b1;
            pc_d      = pc_q + AW'(1);
          end
        end
        S_DRAIN: begin
          infl_v_d = 1'b0;
          if (!infl_v_q) state_d = S_HALTED;
        end
        default: ;
      endcase
    end else if (state_q == S_RUN && halt_req) begin
      state_d = S_DRAIN;
    end

    halted_d = (state_d == S_HALTED);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle synchronous-read memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] address;
  logic [31:0] instruction;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0), .MEM_DEPTH(11)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .address         (address),
    .instruction     (instruction),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .halted          (halted),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    instruction <= (address < 32'd16) ? mem[address[3:0]] : 32'hBAD0_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic word(input logic [31:0] p);
    chk("if_valid", {31'b0, if_valid}, 32'd1);
    chk("if_pc", if_pc, p);
    chk("if_instr", if_instr, 32'h100 + p);
  endtask

  task automatic no_word(input string tag);
    chk(tag, {31'b0, if_valid}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    nc();
    redirect_valid  = 1'b0;
  endtask

  // Redirect to 0 and step until word p is on the outputs.
  task automatic restart_to(input logic [31:0] p);
    redirect(32'd0);
    no_word("rd0_bubble0");
    nc();
    no_word("rd0_bubble1");
    nc();
    word(32'd0);
    for (int i = 1; i <= int'(p); i++) begin
      nc();
      word(32'(i));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = (i < 11) ? 32'h100 + 32'(i) : 32'hEEEE_0000 | 32'(i);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; halt_req = 1'b0;

    // Reset values
    #2;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);

    // Straight-line run from reset to end of memory
    nc(); nc();
    rst_n = 1'b1;
    nc();
    no_word("boot_edge");
    chk("boot_address", address, 32'd0);
    nc();
    no_word("first_issue");
    chk("run_address", address, 32'd1);
    nc();
    word(32'd0);
    for (int i = 1; i <= 10; i++) begin
      nc();
      word(32'(i));
    end
    chk("end_halted_pre", {31'b0, halted}, 32'd0);
    nc();
    no_word("end_drain");
    chk("end_halted", {31'b0, halted}, 32'd1);
    chk("end_address", address, 32'd11);
    nc();
    chk("end_halted_hold", {31'b0, halted}, 32'd1);
    chk("end_address_hold", address, 32'd11);
    chk("end_fault", {31'b0, fetch_fault}, 32'd0);

    // Stall for three cycles while word 3 is presented
    restart_to(32'd3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc();
      word(32'd3);
      chk("stall_replay_addr", address, 32'd4);
    end
    stall = 1'b0;
    nc();
    word(32'd4);
    nc();
    word(32'd5);

    // Redirect to 8 while word 2 is presented
    restart_to(32'd2);
    redirect(32'd8);
    no_word("rd8_bubble0");
    nc();
    no_word("rd8_bubble1");
    for (int i = 8; i <= 10; i++) begin
      nc();
      word(32'(i));
    end
    nc();
    no_word("rd8_end");
    chk("rd8_halted", {31'b0, halted}, 32'd1);

    // Illegal redirect faults and halts; a legal one recovers
    restart_to(32'd1);
    redirect(32'd20);
    no_word("fault_valid");
    chk("fault_set", {31'b0, fetch_fault}, 32'd1);
    chk("fault_halted", {31'b0, halted}, 32'd1);
    redirect(32'd0);
    chk("recover_halted", {31'b0, halted}, 32'd0);
    no_word("recover_bubble0");
    nc();
    no_word("recover_bubble1");
    nc();
    word(32'd0);
    chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);

    // halt_req pulse while word 5 is presented
    restart_to(32'd5);
    halt_req = 1'b1;
    nc();
    halt_req = 1'b0;
    word(32'd6);
    chk("halt_not_yet", {31'b0, halted}, 32'd0);
    nc();
    no_word("halt_done");
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_address", address, 32'd7);

    // halt_req together with stall holds outputs, then drains one word
    restart_to(32'd2);
    halt_req = 1'b1;
    stall    = 1'b1;
    nc();
    halt_req = 1'b0;
    word(32'd2);
    chk("hs_halted", {31'b0, halted}, 32'd0);
    stall = 1'b0;
    nc();
    word(32'd3);
    nc();
    no_word("hs_done");
    chk("hs_halted_done", {31'b0, halted}, 32'd1);

    // Reset asserted mid-run clears everything at once
    restart_to(32'd3);
    rst_n = 1'b0;
    #1;
    no_word("mid_rst_valid");
    chk("mid_rst_pc", if_pc, 32'd0);
    chk("mid_rst_instr", if_instr, 32'd0);
    chk("mid_rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("mid_rst_halted", {31'b0, halted}, 32'd0);
    chk("mid_rst_address", address, 32'd0);
    nc(); nc();
    rst_n = 1'b1;
    nc();
    no_word("re_boot");
    nc();
    no_word("re_issue");
    nc();
    word(32'd0);
    nc();
    word(32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
